kernel_launch_queue: RTL

- Upstream feeder for the block dispatcher.
- Accepts kernel launch descriptors from the host/control interface into a small FIFO.
- Presents one kernel_config at a time, stable for the whole kernel, and drives the dispatcher's start and reset.
- Retires each kernel on the dispatcher's done, counts completions and sequences the next launch.

---
 rtl/kernel_launch_queue_pkg.sv | 25 ++
 rtl/kernel_launch_queue_desc_fifo.sv | 79 +++++++
 rtl/kernel_launch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/kernel_launch_queue_pkg.sv
// Shared types for the kernel launch queue: descriptor layout, launch FSM
// states and the default watchdog limit.
package kernel_launch_queue_pkg;

  localparam int DATA_WIDTH             = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // One kernel launch descriptor as handed to the block dispatcher.
  typedef struct packed {
    logic [7:0]  kernel_id;
    data_t       num_blocks;
    logic [31:0] arg_base;
  } kernel_config_t;

  // Launch sequencing: pick a kernel, reset the dispatcher, run it, retire it.
  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,
    LS_CLEAR  = 2'd1,
    LS_LAUNCH = 2'd2,
    LS_RETIRE = 2'd3
  } launch_state_t;

endpackage

// File: rtl/kernel_launch_queue_desc_fifo.sv
// Circular descriptor FIFO for the kernel launch queue. Registered storage,
// no pass-through: an entry becomes visible at the head the cycle after its
// push. flush_i empties the queue and wins over push/pop in the same cycle.
module kernel_desc_fifo
  import kernel_launch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  kernel_config_t   push_data_i,
  input  logic             pop_i,
  output kernel_config_t   head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // NOTE: the storage array has no reset; count_q alone says which slots are valid.
  kernel_config_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Descriptor storage write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/kernel_launch_queue.sv
// Kernel launch queue: buffers launch descriptors, presents one kernel_config
// at a time to the block dispatcher, sequences its reset/start and retires
// each kernel on dispatcher_done.
// Optional feature: define KERNEL_LAUNCH_TIMEOUT_EN to add a LAUNCH watchdog
// that forces retirement after TIMEOUT_CYCLES and raises sticky timeout_err.
module kernel_launch_queue
  import kernel_launch_queue_pkg::*;
#(
  parameter  int QUEUE_DEPTH    = 4,
  parameter  int CNT_WIDTH      = 16,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int QCNT_W         = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  kernel_config_t       in_config,
  output logic                 in_ready,
  input  logic                 abort,
  output kernel_config_t       kernel_config,
  output logic                 dispatcher_start,
  output logic                 dispatcher_reset,
  input  logic                 dispatcher_done,
  output logic                 kernel_done,
  output logic                 busy,
  output logic [QCNT_W-1:0]    queue_count,
  output logic [CNT_WIDTH-1:0] kernels_completed
`ifdef KERNEL_LAUNCH_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("kernel_launch_queue: QUEUE_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  launch_state_t        state_q, state_d;
  kernel_config_t       cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;
  logic                 aux_rst_q, aux_rst_d;   // one-cycle dispatcher reset after abort/timeout

  kernel_config_t       fifo_head;
  logic [QCNT_W-1:0]    fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop;
  logic                 timeout_hit;

  // Abort blocks both sides of the queue in its cycle; the flush wins anyway,
  // but gating here keeps in_ready honest to the host.
  assign in_ready  = !reset && !abort && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == LS_IDLE) && !fifo_empty && !abort && !reset;

  kernel_desc_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (abort),
    .push_i      (fifo_push),
    .push_data_i (in_config),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef KERNEL_LAUNCH_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d;

  // wd_q counts completed LAUNCH cycles; the TIMEOUT_CYCLES-th one without
  // done is the last.
  assign timeout_hit = (state_q == LS_LAUNCH) && !dispatcher_done && (wd_q == WD_LAST);
  assign timeout_err = terr_q;

  // Watchdog runs only inside LAUNCH and is zero on every entry to it.
  always_comb begin
    wd_d   = (state_q == LS_LAUNCH) ? wd_q + WD_W'(1) : '0;
    terr_d = terr_q || (timeout_hit && !abort);
  end

  // Watchdog and sticky error registers; only reset clears timeout_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Launch sequencing; abort overrides every state transition.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    done_cnt_d = done_cnt_q;
    aux_rst_d  = 1'b0;
    if (abort) begin
      state_d   = LS_IDLE;
      aux_rst_d = 1'b1;
    end else begin
      unique case (state_q)
        LS_IDLE: begin
          if (!fifo_empty) begin
            cfg_d   = fifo_head;
            state_d = LS_CLEAR;
          end
        end
        LS_CLEAR: begin
          // The dispatcher would never report done for zero blocks, so skip it.
          state_d = (cfg_q.num_blocks == '0) ? LS_RETIRE : LS_LAUNCH;
        end
        LS_LAUNCH: begin
          if (dispatcher_done) begin
            state_d = LS_RETIRE;
          end else if (timeout_hit) begin
            state_d   = LS_RETIRE;
            aux_rst_d = 1'b1;
          end
        end
        LS_RETIRE: begin
          done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
          state_d    = LS_IDLE;
        end
        default: state_d = LS_IDLE;
      endcase
    end
  end

  // FSM, active config and completion counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LS_IDLE;
      cfg_q      <= '0;
      done_cnt_q <= '0;
      aux_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      done_cnt_q <= done_cnt_d;
      aux_rst_q  <= aux_rst_d;
    end
  end

  assign kernel_config     = cfg_q;
  assign dispatcher_start  = (state_q == LS_LAUNCH);
  assign dispatcher_reset  = reset || (state_q == LS_CLEAR) || aux_rst_q;
  assign kernel_done       = (state_q == LS_RETIRE) && !abort;
  assign busy              = (state_q != LS_IDLE) || !fifo_empty;
  assign queue_count       = fifo_count;
  assign kernels_completed = done_cnt_q;

endmodule
